// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers responses and
// presents a registered instruction to decode. Optional perf counters: define IF_PERF_CNT_EN.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH      = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   output logic        IF_valid,
   output logic [31:0] IF_pc_out,
   output logic [31:0] IF_instr_out
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {StBoot, StRun, StDrain} state_e;

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        rsp_pc_q, rsp_pc_d;
   logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]        fifo_instr_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [OUT_W-1:0]   outstanding_q, outstanding_d;
   logic [OUT_W-1:0]   discard_q, discard_d;
   logic               valid_d;
   logic [31:0]        pc_out_d, instr_out_d;

   logic               rsp_ok, gnt_ok, push, fifo_empty, avail, take, fifo_wr, fifo_rd;
   logic [31:0]        credit_used, head_pc, head_instr, redirect_target;

   assign redirect_target = redirect_pc & ~32'h3;
   assign imem_addr       = pc_q;
   assign credit_used     = 32'(outstanding_q) + 32'(count_q);

   always_comb begin
      imem_req = (state_q == StRun) && !redirect_valid && (credit_used < FIFO_DEPTH)
                 && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
      // Responses with nothing outstanding are protocol errors and are ignored.
      rsp_ok     = imem_rvalid && (outstanding_q != '0);
      gnt_ok     = imem_req && imem_gnt;
      push       = rsp_ok && !redirect_valid && (discard_q == '0);
      fifo_empty = (count_q == '0);
      avail      = !fifo_empty || push;
      take       = !redirect_valid && !id_stall && avail;
      // With an empty buffer the arriving word bypasses straight into the output register.
      fifo_wr    = push && !(fifo_empty && take);
      fifo_rd    = take && !fifo_empty;
      head_pc    = fifo_empty ? rsp_pc_q : fifo_pc_q[rd_ptr_q];
      head_instr = fifo_empty ? imem_rdata : fifo_instr_q[rd_ptr_q];
   end

   always_comb begin
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      if (redirect_valid) begin
         pc_d          = redirect_target;
         rsp_pc_d      = redirect_target;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
         outstanding_d = outstanding_q - OUT_W'(rsp_ok);
         discard_d     = outstanding_q - OUT_W'(rsp_ok);
      end else begin
         if (gnt_ok) pc_d = pc_q + 32'd4;
         outstanding_d = outstanding_q + OUT_W'(gnt_ok) - OUT_W'(rsp_ok);
         if (rsp_ok && (discard_q != '0)) discard_d = discard_q - 1'b1;
         if (push) rsp_pc_d = rsp_pc_q + 32'd4;
         if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
         if (fifo_rd) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot:         state_d = StRun;
         StRun, StDrain: state_d = (discard_d != '0) ? StDrain : StRun;
         default:        state_d = StBoot;
      endcase
   end

   always_comb begin
      valid_d     = IF_valid;
      pc_out_d    = IF_pc_out;
      instr_out_d = IF_instr_out;
      if (redirect_valid) begin
         valid_d     = 1'b0;
         instr_out_d = NOP_INSTR;
      end else if (!id_stall) begin
         if (avail) begin
            valid_d     = 1'b1;
            pc_out_d    = head_pc;
            instr_out_d = head_instr;
         end else begin
            valid_d     = 1'b0;
            instr_out_d = NOP_INSTR;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         IF_valid      <= 1'b0;
         IF_pc_out     <= 32'h0;
         IF_instr_out  <= NOP_INSTR;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         IF_valid      <= valid_d;
         IF_pc_out     <= pc_out_d;
         IF_instr_out  <= instr_out_d;
      end
   end

   // Buffer storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
         fifo_instr_q[wr_ptr_q] <= imem_rdata;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= 32'h0;
         perf_stall_cnt <= 32'h0;
      end else begin
         if (take) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (id_stall && IF_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

   a_rvalid_without_outstanding: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (outstanding_q != '0));
   a_gnt_without_req: assert property (@(posedge clk) disable iff (rst)
      imem_gnt |-> imem_req);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic checked
// against an instruction-stream reference model. Define IF_PERF_CNT_EN to check perf counters.
`timescale 1ns/1ps
module tb_if_fetch_stage;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam int          MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid, id_stall;
   logic [31:0] redirect_pc;
   logic        IF_valid;
   logic [31:0] IF_pc_out, IF_instr_out;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   if_fetch_stage #(
      .RESET_PC        (32'h0000_0000),
      .FIFO_DEPTH      (2),
      .MAX_OUTSTANDING (2),
      .NOP_INSTR       (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .IF_valid       (IF_valid),
      .IF_pc_out      (IF_pc_out),
      .IF_instr_out   (IF_instr_out)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] pend[$];      // granted addresses awaiting a memory response
   logic [31:0] fetch_pc;     // next address the stage should request
   logic [31:0] exp_pc;       // next PC the stage should deliver to decode
   int          n_deliv = 0;
   int          n_stall_cyc = 0;
   logic        last_req;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs at the negedge, sample and check at the following negedge.
   task automatic step(input logic rd, input logic [31:0] rpc, input logic st,
                       input int gnt_pct, input int rv_pct);
      logic        rv, req, gnt, pv;
      logic [31:0] paddr, ppc, pinstr;
      rv = (pend.size() != 0) && ($urandom_range(99) < rv_pct);
      imem_gnt       = 1'b0;
      redirect_valid = rd;
      redirect_pc    = rpc;
      id_stall       = st;
      imem_rvalid    = rv;
      imem_rdata     = rv ? mem_word(pend[0]) : $urandom;
      #1;
      req      = imem_req;
      gnt      = req && ($urandom_range(99) < gnt_pct);
      imem_gnt = gnt;
      if (rd) chk("req_during_redirect", req, 1'b0);
      if (pend.size() >= MAX_OUT) chk("req_credit", req, 1'b0);
      paddr  = imem_addr;
      pv     = IF_valid;
      ppc    = IF_pc_out;
      pinstr = IF_instr_out;
      if (st && pv) n_stall_cyc++;
      @(posedge clk);
      @(negedge clk);
      if (rv) void'(pend.pop_front());
      if (gnt) pend.push_back(paddr);
      if (rd) begin
         chk("redirect_valid", IF_valid, 1'b0);
         chk("redirect_instr", IF_instr_out, NOP);
         chk("redirect_pc_hold", IF_pc_out, ppc);
         exp_pc   = rpc & ~32'h3;
         fetch_pc = rpc & ~32'h3;
      end else begin
         if (gnt) fetch_pc = fetch_pc + 32'd4;
         if (st) begin
            chk("stall_valid_hold", IF_valid, pv);
            chk("stall_pc_hold", IF_pc_out, ppc);
            chk("stall_instr_hold", IF_instr_out, pinstr);
         end else if (IF_valid) begin
            chk("deliver_pc", IF_pc_out, exp_pc);
            chk("deliver_instr", IF_instr_out, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
         end else begin
            chk("bubble_instr", IF_instr_out, NOP);
            chk("bubble_pc_hold", IF_pc_out, ppc);
         end
      end
      chk("imem_addr", imem_addr, fetch_pc);
      last_req = req;
   endtask

   initial begin
      int   d0;
      logic found;
      rst            = 1'b1;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_stall       = 1'b0;
      fetch_pc       = 32'h0;
      exp_pc         = 32'h0;
      last_req       = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", IF_valid, 1'b0);
      chk("rst_pc_out", IF_pc_out, 32'h0);
      chk("rst_instr", IF_instr_out, NOP);
      chk("rst_addr", imem_addr, 32'h0);
      rst = 1'b0;

      // Boot latency with a one-cycle memory.
      step(1'b0, 32'h0, 1'b0, 100, 100);
      chk("lat_c1_valid", IF_valid, 1'b0);
      step(1'b0, 32'h0, 1'b0, 100, 100);
      chk("lat_c2_valid", IF_valid, 1'b0);
      step(1'b0, 32'h0, 1'b0, 100, 100);
      chk("lat_c3_valid", IF_valid, 1'b1);
      chk("lat_c3_pc", IF_pc_out, 32'h0);
      step(1'b0, 32'h0, 1'b0, 100, 100);
      chk("lat_c4_pc", IF_pc_out, 32'h4);

      // Decode stall long enough to fill the buffer.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'h0, 1'b1, 100, 100);
         if (i >= 1) chk("stall_req_low", last_req, 1'b0);
      end
      d0 = n_deliv;
      repeat (4) step(1'b0, 32'h0, 1'b0, 100, 100);
      chk("stall_resume", 32'(n_deliv - d0 >= 3), 32'h1);

      // Redirect with two requests in flight.
      for (int i = 0; i < 10 && pend.size() < 2; i++) step(1'b0, 32'h0, 1'b0, 100, 0);
      step(1'b1, 32'h0000_0203, 1'b0, 100, 0);
      chk("redir_addr", imem_addr, 32'h0000_0200);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 32'h0, 1'b0, 100, 100);
         found = IF_valid;
      end
      chk("redir_deliver", found, 1'b1);
      chk("redir_first_pc", IF_pc_out, 32'h0000_0200);

      // Redirect coinciding with a response and a decode stall.
      for (int i = 0; i < 10 && pend.size() < 2; i++) step(1'b0, 32'h0, 1'b0, 100, 0);
      step(1'b1, 32'h0000_1000, 1'b1, 100, 100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 32'h0, 1'b0, 100, 100);
         found = IF_valid;
      end
      chk("redir_rv_deliver", found, 1'b1);
      chk("redir_rv_first_pc", IF_pc_out, 32'h0000_1000);

      // PC wrap at the top of the address space.
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 100, 100);
      chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
      for (int i = 0; i < 20 && imem_addr == 32'hFFFF_FFFC; i++)
         step(1'b0, 32'h0, 1'b0, 100, 100);
      chk("wrap_addr", imem_addr, 32'h0);
      repeat (6) step(1'b0, 32'h0, 1'b0, 100, 100);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                        : ($urandom & 32'h0000_FFFF);
         step(($urandom_range(29) == 0), tgt, ($urandom_range(3) == 0), 70, 60);
      end

      d0 = n_deliv;
      repeat (20) step(1'b0, 32'h0, 1'b0, 100, 100);
      chk("final_progress", 32'(n_deliv - d0 >= 10), 32'h1);

`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'(n_deliv));
      chk("perf_stall_cnt", perf_stall_cnt, 32'(n_stall_cyc));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
